// File: rtl/rtype_issue_unit_pkg.sv
// Shared constants for the R-type issue unit: opcode/funct encodings,
// instruction field positions and register-file geometry.
package rtype_issue_unit_pkg;

   localparam int NUM_REGS = 32;
   localparam int REG_AW   = 5;
   localparam int INSTR_W  = 32;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] FN_ADD   = 6'd27;
   localparam logic [5:0] FN_SUB   = 6'd28;
   localparam logic [5:0] FN_AND   = 6'd29;
   localparam logic [5:0] FN_OR    = 6'd30;
   localparam logic [5:0] FN_SRL   = 6'd31;
   localparam logic [5:0] FN_SLL   = 6'd32;

   // {op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]}
   localparam int OP_LSB = 26;
   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;
   localparam int RD_LSB = 11;
   localparam int SH_LSB = 6;
   localparam int FN_LSB = 0;

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
      logic fn_ok;
      case (funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SRL, FN_SLL: fn_ok = 1'b1;
         default:                                       fn_ok = 1'b0;
      endcase
      return (op == OP_RTYPE) && fn_ok;
   endfunction

endpackage

// File: rtl/rtype_issue_unit_reg_file_32x32.sv
// 32-entry register file: two combinational operand reads plus a debug read,
// one synchronous write port shared by writeback (priority) and debug preload.
module reg_file_32x32
   import rtype_issue_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [4:0]        rs_addr_i,
   input  logic [4:0]        rt_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   input  logic              wb_we_i,
   input  logic [4:0]        wb_waddr_i,
   input  logic [DATA_W-1:0] wb_wdata_i,
   input  logic              dbg_we_i,
   input  logic [4:0]        dbg_waddr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   input  logic [4:0]        dbg_raddr_i,
   output logic [DATA_W-1:0] dbg_rdata_o
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   // Entry 0 is only ever reset, so $0 reads zero regardless of writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wb_we_i && (wb_waddr_i == 5'(i))) begin
               regs_q[i] <= wb_wdata_i;
            end else if (dbg_we_i && (dbg_waddr_i == 5'(i))) begin
               regs_q[i] <= dbg_wdata_i;
            end
         end
      end
   end

   assign rs_data_o   = (rs_addr_i   == '0) ? '0 : regs_q[rs_addr_i];
   assign rt_data_o   = (rt_addr_i   == '0) ? '0 : regs_q[rt_addr_i];
   assign dbg_rdata_o = (dbg_raddr_i == '0) ? '0 : regs_q[dbg_raddr_i];

endmodule

// File: rtl/rtype_issue_unit.sv
// Issue/writeback stage around an external combinational ALU: ID decode with
// EX->ID forwarding, EX operand register, WB register with flags and retire count.
module rtype_issue_unit
   import rtype_issue_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic [DATA_W-1:0]  alu_src1,
   output logic [DATA_W-1:0]  alu_src2,
   output logic [5:0]         alu_funct,
   output logic [4:0]         alu_shamt,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic               alu_zero,
   input  logic               alu_carry,
   output logic               wb_valid,
   output logic [4:0]         wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   output logic               flag_zero,
   output logic               flag_carry,
   output logic               illegal,
   output logic [CNT_W-1:0]   retire_cnt,
   input  logic               dbg_we,
   input  logic [4:0]         dbg_waddr,
   input  logic [DATA_W-1:0]  dbg_wdata,
   input  logic [4:0]         dbg_raddr,
   output logic [DATA_W-1:0]  dbg_rdata
);

   // ID stage: handshake is valid&ready at a rising edge; ready drops only in reset.
   logic [5:0]        id_op, id_funct;
   logic [4:0]        id_rs, id_rt, id_rd, id_shamt;
   logic              id_accept, id_legal;
   logic [DATA_W-1:0] rf_rs_data, rf_rt_data;
   logic [DATA_W-1:0] id_src1, id_src2;

   assign id_op     = instr[OP_LSB +: 6];
   assign id_rs     = instr[RS_LSB +: REG_AW];
   assign id_rt     = instr[RT_LSB +: REG_AW];
   assign id_rd     = instr[RD_LSB +: REG_AW];
   assign id_shamt  = instr[SH_LSB +: 5];
   assign id_funct  = instr[FN_LSB +: 6];

   assign instr_ready = ~rst;
   assign id_accept   = instr_valid & instr_ready;
   assign id_legal    = is_legal(id_op, id_funct);

   // EX stage registers
   logic              ex_valid_q, ex_valid_d;
   logic [DATA_W-1:0] ex_src1_q, ex_src1_d;
   logic [DATA_W-1:0] ex_src2_q, ex_src2_d;
   logic [5:0]        ex_funct_q, ex_funct_d;
   logic [4:0]        ex_shamt_q, ex_shamt_d;
   logic [4:0]        ex_rd_q, ex_rd_d;
   logic              ex_fwd_ok;

   // WB stage registers
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              flag_zero_q, flag_zero_d;
   logic              flag_carry_q, flag_carry_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic              rf_we;

   reg_file_32x32 #(.DATA_W(DATA_W)) u_rf (
      .clk_i       (clk),
      .rst_i       (rst),
      .rs_addr_i   (id_rs),
      .rt_addr_i   (id_rt),
      .rs_data_o   (rf_rs_data),
      .rt_data_o   (rf_rt_data),
      .wb_we_i     (rf_we),
      .wb_waddr_i  (ex_rd_q),
      .wb_wdata_i  (alu_result),
      .dbg_we_i    (dbg_we),
      .dbg_waddr_i (dbg_waddr),
      .dbg_wdata_i (dbg_wdata),
      .dbg_raddr_i (dbg_raddr),
      .dbg_rdata_o (dbg_rdata)
   );

   // The op in EX writes its rd on this same edge, so its result bypasses the regfile.
   assign ex_fwd_ok = ex_valid_q && (ex_rd_q != '0);
   assign id_src1   = (ex_fwd_ok && (id_rs == ex_rd_q)) ? alu_result : rf_rs_data;
   assign id_src2   = (ex_fwd_ok && (id_rt == ex_rd_q)) ? alu_result : rf_rt_data;

   always_comb begin
      ex_valid_d = 1'b0;
      ex_src1_d  = '0;
      ex_src2_d  = '0;
      ex_funct_d = '0;
      ex_shamt_d = '0;
      ex_rd_d    = '0;
      illegal_d  = illegal_q;
      if (id_accept) begin
         if (id_legal) begin
            ex_valid_d = 1'b1;
            ex_src1_d  = id_src1;
            ex_src2_d  = id_src2;
            ex_funct_d = id_funct;
            ex_shamt_d = id_shamt;
            ex_rd_d    = id_rd;
         end else begin
            illegal_d  = 1'b1;
         end
      end
   end

   assign rf_we = ex_valid_q && (ex_rd_q != '0);

   always_comb begin
      wb_valid_d   = 1'b0;
      wb_addr_d    = wb_addr_q;
      wb_data_d    = wb_data_q;
      flag_zero_d  = flag_zero_q;
      flag_carry_d = flag_carry_q;
      retire_cnt_d = retire_cnt_q;
      if (ex_valid_q) begin
         wb_valid_d   = 1'b1;
         wb_addr_d    = ex_rd_q;
         wb_data_d    = alu_result;
         flag_zero_d  = alu_zero;
         // A zero-distance SRL leaves the ALU carry undefined.
         flag_carry_d = ((ex_funct_q == FN_SRL) && (ex_shamt_q == '0)) ? 1'b0 : alu_carry;
         retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_src1_q    <= '0;
         ex_src2_q    <= '0;
         ex_funct_q   <= '0;
         ex_shamt_q   <= '0;
         ex_rd_q      <= '0;
         wb_valid_q   <= 1'b0;
         wb_addr_q    <= '0;
         wb_data_q    <= '0;
         flag_zero_q  <= 1'b0;
         flag_carry_q <= 1'b0;
         illegal_q    <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_src1_q    <= ex_src1_d;
         ex_src2_q    <= ex_src2_d;
         ex_funct_q   <= ex_funct_d;
         ex_shamt_q   <= ex_shamt_d;
         ex_rd_q      <= ex_rd_d;
         wb_valid_q   <= wb_valid_d;
         wb_addr_q    <= wb_addr_d;
         wb_data_q    <= wb_data_d;
         flag_zero_q  <= flag_zero_d;
         flag_carry_q <= flag_carry_d;
         illegal_q    <= illegal_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign alu_src1   = ex_src1_q;
   assign alu_src2   = ex_src2_q;
   assign alu_funct  = ex_funct_q;
   assign alu_shamt  = ex_shamt_q;
   assign wb_valid   = wb_valid_q;
   assign wb_addr    = wb_addr_q;
   assign wb_data    = wb_data_q;
   assign flag_zero  = flag_zero_q;
   assign flag_carry = flag_carry_q;
   assign illegal    = illegal_q;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_rtype_issue_unit.sv
// Bench for rtype_issue_unit: behavioural ALU on the alu_* ports, shadow
// register-file model feeding an expected-writeback queue checked at wb_valid.
module tb_rtype_issue_unit;
   import rtype_issue_unit_pkg::*;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam int W      = 5 + DATA_W + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              instr_valid;
   logic [31:0]       instr;
   logic              instr_ready;
   logic [DATA_W-1:0] alu_src1, alu_src2, alu_result;
   logic [5:0]        alu_funct;
   logic [4:0]        alu_shamt;
   logic              alu_zero, alu_carry;
   logic              wb_valid;
   logic [4:0]        wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              flag_zero, flag_carry, illegal;
   logic [CNT_W-1:0]  retire_cnt;
   logic              dbg_we;
   logic [4:0]        dbg_waddr, dbg_raddr;
   logic [DATA_W-1:0] dbg_wdata, dbg_rdata;

   rtype_issue_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_funct(alu_funct), .alu_shamt(alu_shamt),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .flag_zero(flag_zero), .flag_carry(flag_carry), .illegal(illegal), .retire_cnt(retire_cnt),
      .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   // Clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ALU: shifts act on src2 (rt); SUB carry is borrow; zero-distance SRL returns junk carry 1.
   function automatic logic [DATA_W:0] alu_f(input logic [5:0] fn, input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b, input logic [4:0] sh);
      logic [DATA_W:0] t;
      case (fn)
         FN_ADD:  return {1'b0, a} + {1'b0, b};
         FN_SUB:  return {(a < b), a - b};
         FN_AND:  return {1'b0, a & b};
         FN_OR:   return {1'b0, a | b};
         FN_SRL:  begin t = {b, 1'b0} >> sh; return {((sh == '0) ? 1'b1 : t[0]), b >> sh}; end
         FN_SLL:  begin t = {1'b0, b} << sh; return {t[DATA_W], b << sh}; end
         default: return '0;
      endcase
   endfunction

   assign {alu_carry, alu_result} = alu_f(alu_funct, alu_src1, alu_src2, alu_shamt);
   assign alu_zero = (alu_result == '0);

   // Scoreboard state
   int                checks = 0;
   int                errors = 0;
   logic [W-1:0]      exp_q[$];
   int                due_q[$];
   logic [DATA_W-1:0] ref_rf [32];
   logic [CNT_W-1:0]  exp_retire = '0;
   logic              done = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("wb_unexpected", 64'(wb_valid), 64'd0);
         end else begin
            logic [W-1:0] e;
            int d;
            e = exp_q.pop_front();
            d = due_q.pop_front();
            check("wb_addr_data_flags", {wb_addr, wb_data, flag_zero, flag_carry}, e);
            check("wb_latency", 64'(cyc), 64'(d));
         end
      end
   end

   // Driver tasks (all start and end #1 after a rising edge)
   function automatic logic [31:0] rw(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] sh);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   task automatic issue(input logic [31:0] w, input bit expect_wb = 1'b1);
      logic [5:0]        op, fn;
      logic [4:0]        rs, rt, rd, sh;
      logic [DATA_W-1:0] a, b, r;
      logic [DATA_W:0]   ar;
      logic              c;
      op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
      instr_valid = 1'b1;
      instr       = w;
      if (expect_wb && (op == 6'd0) && (fn >= 6'd27) && (fn <= 6'd32)) begin
         a  = (rs == '0) ? '0 : ref_rf[rs];
         b  = (rt == '0) ? '0 : ref_rf[rt];
         ar = alu_f(fn, a, b, sh);
         r  = ar[DATA_W-1:0];
         c  = ((fn == FN_SRL) && (sh == '0)) ? 1'b0 : ar[DATA_W];
         exp_q.push_back({rd, r, (r == '0), c});
         due_q.push_back(cyc + 2);
         if (rd != '0) ref_rf[rd] = r;
         exp_retire++;
      end
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr       = '0;
   endtask

   task automatic preload(input logic [4:0] a, input logic [DATA_W-1:0] d, input bit upd = 1'b1);
      dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
      if (upd && (a != '0)) ref_rf[a] = d;
      @(posedge clk); #1;
      dbg_we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic rd_check(input string tag, input logic [4:0] a, input logic [DATA_W-1:0] e);
      dbg_raddr = a;
      #1;
      check(tag, dbg_rdata, e);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0) && (n < 20)) begin @(posedge clk); #1; n++; end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
      idle(1);
      check("retire_cnt", retire_cnt, exp_retire);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      check("watchdog", 64'(done), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
      rst = 1'b1; instr_valid = 1'b0; instr = '0;
      dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0; dbg_raddr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("ready_in_reset", 64'(instr_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("ready_after_reset", 64'(instr_ready), 64'd1);
      check("rst_alu_src", {alu_src1, alu_src2}, 64'd0);
      check("rst_alu_ctl", {alu_funct, alu_shamt}, 64'd0);
      check("rst_wb", {wb_valid, wb_addr, wb_data}, 64'd0);
      check("rst_flags", {flag_zero, flag_carry, illegal, retire_cnt}, 64'd0);
      for (int a = 0; a < 32; a++) rd_check("rst_regfile", 5'(a), '0);
      idle(1);

      // Basic ADD and latency
      preload(5'd1, 32'd5);
      preload(5'd2, 32'd3);
      issue(rw(FN_ADD, 5'd3, 5'd1, 5'd2, 5'd0));
      drain();
      rd_check("dbg_r3", 5'd3, 32'd8);
      idle(1);

      // Back-to-back dependent ops: SUB sees $3 through the forward path
      issue(rw(FN_ADD, 5'd3, 5'd1, 5'd2, 5'd0));
      issue(rw(FN_SUB, 5'd4, 5'd3, 5'd1, 5'd0));
      check("fwd_src1", alu_src1, 32'd8);
      check("fwd_funct", 64'(alu_funct), 64'(FN_SUB));
      drain();

      // Borrow, shifts including zero-distance SRL
      issue(rw(FN_SUB, 5'd5, 5'd2, 5'd1, 5'd0));
      issue(rw(FN_SRL, 5'd8, 5'd0, 5'd1, 5'd0));
      issue(rw(FN_SRL, 5'd9, 5'd0, 5'd1, 5'd1));
      issue(rw(FN_SLL, 5'd10, 5'd0, 5'd2, 5'd31));
      issue(rw(FN_AND, 5'd13, 5'd5, 5'd1, 5'd0));
      drain();
      rd_check("dbg_r5", 5'd5, 32'hFFFF_FFFE);

      // $0 destination, then reading $0 must not forward
      idle(1);
      issue(rw(FN_ADD, 5'd0, 5'd1, 5'd2, 5'd0));
      issue(rw(FN_OR, 5'd6, 5'd0, 5'd0, 5'd0));
      drain();
      check("flag_zero_after_or", 64'(flag_zero), 64'd1);
      rd_check("dbg_r0", 5'd0, '0);
      rd_check("dbg_r6", 5'd6, '0);
      idle(1);

      // WB write beats a same-edge debug write to the same register
      issue(rw(FN_ADD, 5'd7, 5'd1, 5'd2, 5'd0));
      preload(5'd7, 32'd99, 1'b0);
      drain();
      rd_check("wb_beats_dbg", 5'd7, 32'd8);
      idle(1);

      // ID read sees the old value while a debug write to that register lands
      dbg_we = 1'b1; dbg_waddr = 5'd7; dbg_wdata = 32'd50;
      issue(rw(FN_ADD, 5'd11, 5'd7, 5'd1, 5'd0));
      dbg_we = 1'b0;
      ref_rf[7] = 32'd50;
      drain();
      rd_check("dbg_r7_new", 5'd7, 32'd50);
      rd_check("dbg_r11_old_operand", 5'd11, 32'd13);
      idle(1);

      // Illegal words are bubbles and set the sticky flag
      check("illegal_clear", 64'(illegal), 64'd0);
      issue({6'h23, 26'h0421800});
      issue(rw(6'd33, 5'd12, 5'd1, 5'd2, 5'd0));
      drain();
      check("illegal_set", 64'(illegal), 64'd1);
      issue(rw(FN_OR, 5'd12, 5'd1, 5'd2, 5'd0));
      drain();
      check("illegal_sticky", 64'(illegal), 64'd1);

      // Random mix with gaps; retire counter wraps at CNT_W bits
      for (int i = 1; i < 8; i++) preload(5'(i), $urandom());
      for (int i = 0; i < 40; i++) begin
         logic [5:0] fn;
         logic [4:0] sh;
         fn = 6'($urandom_range(27, 32));
         sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         if ($urandom_range(0, 7) == 0)
            issue({6'($urandom_range(1, 63)), 20'($urandom()), 6'(fn)});
         else
            issue(rw(fn, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), sh));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      drain();
      for (int a = 1; a < 8; a++) rd_check("rand_regfile", 5'(a), ref_rf[a]);
      idle(1);

      // Reset one cycle after accepting an op: nothing retires, state cleared
      preload(5'd12, 32'h1234);
      issue(rw(FN_ADD, 5'd12, 5'd1, 5'd2, 5'd0), 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
      exp_retire = '0;
      idle(4);
      check("post_rst_retire", retire_cnt, exp_retire);
      check("post_rst_illegal", 64'(illegal), 64'd0);
      rd_check("post_rst_r12", 5'd12, ref_rf[12]);
      rd_check("post_rst_r1", 5'd1, ref_rf[1]);

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
